sync_supervisor: RTL and testbench
==================================

Name: sync_supervisor

Overview:
Controller that sequences the PCS code-group synchronization block. It holds the synchronizer in reset at start-up and on restart, and debounces the PMA signal-detect. It selects the synchronizer's 10-bit input (PMA receive or transmit loopback) and supervises CODE_SYNC to report link status, count sync losses and force a resynchronization on timeout. It sits between the PMA interface and the synchronization block, and its outputs drive that block's RESET, SIGNAL_DETECT, SIGNAL_CHANGE and PUDI inputs.

Parameters:
RST_CYCLES, 4, cycles SYNC_RESET is held high per reset request (>=1)
DEBOUNCE, 8, consecutive stable raw samples required before filtered signal-detect changes (>=1)
SYNC_TIMEOUT, 1024, cycles allowed in WAIT_SYNC before forced resync (>=2)
CNT_W, 8, width of LOSS_COUNT

Ports:
CLK  in  1  clock, all logic rising-edge
RESET  in  1  asynchronous, active-low reset
SIGNAL_DETECT_RAW  in  1  unfiltered PMA signal detect, asynchronous to CLK
MR_LOOPBACK  in  1  management loopback enable
MR_RESTART  in  1  management restart, level; acted on while high
RX_CODE  in  10  code-group from PMA
TX_CODE  in  10  code-group from PCS transmit (loopback source)
CODE_SYNC  in  1  sync indication from synchronization block
SYNC_RESET  out  1  active-high reset to synchronization block
SIGNAL_DETECT  out  1  filtered signal detect
SIGNAL_CHANGE  out  1  one-cycle pulse on any SIGNAL_DETECT edge
PUDI  out  10  registered code-group to synchronization block
LINK_UP  out  1  high only in LINK_OK
LOSS_COUNT  out  CNT_W  saturating count of CODE_SYNC losses from LINK_OK

Behaviour:
- Reset values (RESET=0): state=HOLD_RST, SYNC_RESET=1, SIGNAL_DETECT=0, SIGNAL_CHANGE=0, PUDI=0, LINK_UP=0, LOSS_COUNT=0, all counters 0.
- SIGNAL_DETECT_RAW passes a 2-flop synchronizer before any use.
- Debounce:
  - Counter clears whenever the synchronized raw value equals the filtered value.
  - Otherwise it increments; on reaching DEBOUNCE, the filtered value takes the new value and the counter clears.
  - Raw-to-filtered latency is 2+DEBOUNCE cycles.
- Loopback: while MR_LOOPBACK=1, SIGNAL_DETECT is forced to 1 and the debouncer is held cleared. A filtered edge caused by entering or leaving loopback still pulses SIGNAL_CHANGE.
- SIGNAL_CHANGE is registered and asserts the cycle after SIGNAL_DETECT changes, for exactly one cycle.
- PUDI = (MR_LOOPBACK ? TX_CODE : RX_CODE), registered, 1-cycle latency, updated every cycle in every state.
- FSM states: HOLD_RST, WAIT_SIGNAL, WAIT_SYNC, LINK_OK.
  - HOLD_RST: SYNC_RESET=1; count RST_CYCLES cycles, then go to WAIT_SIGNAL. SYNC_RESET=0 from the cycle of entry to WAIT_SIGNAL.
  - WAIT_SIGNAL: when SIGNAL_DETECT=1, go to WAIT_SYNC and clear the timeout counter.
  - WAIT_SYNC:
    - CODE_SYNC=1 -> LINK_OK.
    - Otherwise increment the timeout counter; at SYNC_TIMEOUT-1 -> HOLD_RST (forced resync).
  - LINK_OK: LINK_UP=1. CODE_SYNC=0 -> WAIT_SYNC, timeout counter cleared, LOSS_COUNT+1 saturating at all-ones.
- Priority, highest first, applied in every state:
  1. RESET low.
  2. MR_RESTART=1 -> HOLD_RST, with the RST_CYCLES count restarted each cycle it remains high.
  3. SIGNAL_DETECT=0 while not in HOLD_RST -> WAIT_SIGNAL.
  4. The per-state transitions above.
- A CODE_SYNC drop in the same cycle as a signal loss goes to WAIT_SIGNAL and does not increment LOSS_COUNT.
- LOSS_COUNT is cleared only by RESET, not by MR_RESTART.
- LINK_UP is a registered state decode: it falls the cycle after the state leaves LINK_OK.
- A RESET assertion mid-operation returns all outputs to their reset values immediately (asynchronous).

Decomposition:
- Shared package pcs_pkg holds:
  - the state encoding constants HOLD_RST=0, WAIT_SIGNAL=1, WAIT_SYNC=2, LINK_OK=3;
  - the 10-bit code-group width constant CG_W=10;
  - the K28.5 comma patterns used by the bench.
- One sub-module, sd_debounce, contains the 2-flop synchronizer, the debounce counter, the filtered output and the change pulse, with a force input for loopback. The FSM, mux and counters stay in sync_supervisor.

Test Plan:
- Reset release with RAW=1 and CODE_SYNC=0 -> SYNC_RESET high exactly 4 cycles; SIGNAL_DETECT rises 10 cycles after sync start with a 1-cycle SIGNAL_CHANGE; state reaches WAIT_SYNC.
- Raw glitch 0-1-0 of 5 cycles, DEBOUNCE=8 -> SIGNAL_DETECT stays 0 and no SIGNAL_CHANGE.
- Link up, then CODE_SYNC dropped 3 separate times -> LOSS_COUNT=3 and LINK_UP low 1 cycle after each drop. With CNT_W=2 and 5 drops -> LOSS_COUNT saturates at 3.
- CODE_SYNC held 0 in WAIT_SYNC with SYNC_TIMEOUT=16 -> re-enter HOLD_RST after 16 cycles and SYNC_RESET pulses high for 4 cycles.
- MR_LOOPBACK=1 with RAW=0, TX_CODE=0x17C, RX_CODE=0x283 -> PUDI=0x17C one cycle later, SIGNAL_DETECT=1 with a SIGNAL_CHANGE pulse. Deassert loopback -> PUDI=0x283, SIGNAL_DETECT=0, state goes to WAIT_SIGNAL.
- MR_RESTART pulsed in LINK_OK with CODE_SYNC=0 in the same cycle -> HOLD_RST, LOSS_COUNT unchanged; a RESET pulse mid-WAIT_SYNC zeroes LOSS_COUNT asynchronously.

Source files
------------

// File: rtl/pcs_pkg.sv
// pcs_pkg: constants shared by the PCS synchronization supervisor and its
// environment.
//   CG_W                 10-bit code-group width
//   HOLD_RST..LINK_OK    supervisor FSM state encoding
//   K28_5_RDN/K28_5_RDP  K28.5 comma code-groups, bit a in the LSB
//   is_comma()           true for either K28.5 running-disparity variant
package pcs_pkg;

  localparam int CG_W = 10;

  typedef logic [CG_W-1:0] code_group_t;

  localparam logic [1:0] HOLD_RST    = 2'd0;
  localparam logic [1:0] WAIT_SIGNAL = 2'd1;
  localparam logic [1:0] WAIT_SYNC   = 2'd2;
  localparam logic [1:0] LINK_OK     = 2'd3;

  // abcdei fghj = 001111 1010 (RD-) and 110000 0101 (RD+), with a in bit 0.
  localparam code_group_t K28_5_RDN = 10'h17C;
  localparam code_group_t K28_5_RDP = 10'h283;

  function automatic logic is_comma(input code_group_t cg);
    return (cg == K28_5_RDN) || (cg == K28_5_RDP);
  endfunction

endpackage

// File: rtl/sync_supervisor_if.sv
// sync_supervisor_if: signals between the supervisor, the PMA/management side
// and the code-group synchronization block.
//   PMA/management -> supervisor : SIGNAL_DETECT_RAW, MR_LOOPBACK, MR_RESTART,
//                                  RX_CODE, TX_CODE, CODE_SYNC
//   supervisor -> sync block     : SYNC_RESET, SIGNAL_DETECT, SIGNAL_CHANGE,
//                                  PUDI, plus status LINK_UP, LOSS_COUNT
// Modport slave is the supervisor's view; master is the environment's view.
interface sync_supervisor_if #(
  parameter int CNT_W = 8
) ();
  import pcs_pkg::*;

  logic              SIGNAL_DETECT_RAW;
  logic              MR_LOOPBACK;
  logic              MR_RESTART;
  code_group_t       RX_CODE;
  code_group_t       TX_CODE;
  logic              CODE_SYNC;
  logic              SYNC_RESET;
  logic              SIGNAL_DETECT;
  logic              SIGNAL_CHANGE;
  code_group_t       PUDI;
  logic              LINK_UP;
  logic [CNT_W-1:0]  LOSS_COUNT;

  modport slave (
    input  SIGNAL_DETECT_RAW, MR_LOOPBACK, MR_RESTART, RX_CODE, TX_CODE, CODE_SYNC,
    output SYNC_RESET, SIGNAL_DETECT, SIGNAL_CHANGE, PUDI, LINK_UP, LOSS_COUNT
  );

  modport master (
    output SIGNAL_DETECT_RAW, MR_LOOPBACK, MR_RESTART, RX_CODE, TX_CODE, CODE_SYNC,
    input  SYNC_RESET, SIGNAL_DETECT, SIGNAL_CHANGE, PUDI, LINK_UP, LOSS_COUNT
  );

endinterface

// File: rtl/sd_debounce.sv
// sd_debounce: synchronizes and debounces the PMA signal-detect.
//   CLK       clock
//   RESET     asynchronous active-low reset
//   raw_i     unfiltered signal detect, asynchronous to CLK
//   force_i   loopback: output forced high, debouncer held cleared
//   sd_o      filtered signal detect
//   change_o  one-cycle pulse the cycle after sd_o changes
// Latency raw_i -> sd_o is 2 + DEBOUNCE cycles.
module sd_debounce #(
  parameter int DEBOUNCE = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw_i,
  input  logic force_i,
  output logic sd_o,
  output logic change_o
);

  localparam int DCW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic           meta_q, sync_q;
  logic           filt_q, filt_d;
  logic [DCW-1:0] cnt_q, cnt_d;
  logic           sd_q, sd_d;
  logic           sd_prev_q;
  logic           change_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (force_i) begin
      filt_d = 1'b0;
      cnt_d  = '0;
    end else if (sync_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == DCW'(DEBOUNCE - 1)) begin
      // This cycle is the DEBOUNCE-th consecutive differing sample.
      filt_d = sync_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + DCW'(1);
    end
    sd_d = force_i | filt_d;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      filt_q    <= 1'b0;
      cnt_q     <= '0;
      sd_q      <= 1'b0;
      sd_prev_q <= 1'b0;
      change_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // this is what makes meta_q -> sync_q a true two-stage synchronizer.
      meta_q    <= raw_i;
      sync_q    <= meta_q;
      filt_q    <= filt_d;
      cnt_q     <= cnt_d;
      sd_q      <= sd_d;
      sd_prev_q <= sd_q;
      change_q  <= sd_q ^ sd_prev_q;
    end
  end

  assign sd_o     = sd_q;
  assign change_o = change_q;

endmodule

// File: rtl/sync_supervisor.sv
// sync_supervisor: sequences the PCS code-group synchronization block.
//   CLK    clock, all logic on the rising edge
//   RESET  asynchronous active-low reset
//   bus    sync_supervisor_if.slave: PMA/management inputs, CODE_SYNC from the
//          synchronizer; SYNC_RESET, SIGNAL_DETECT, SIGNAL_CHANGE, PUDI to it;
//          LINK_UP and saturating LOSS_COUNT as status
// FSM: HOLD_RST -> WAIT_SIGNAL -> WAIT_SYNC <-> LINK_OK. MR_RESTART and loss
// of filtered signal-detect override the per-state transitions.
module sync_supervisor
  import pcs_pkg::*;
#(
  parameter int RST_CYCLES   = 4,
  parameter int DEBOUNCE     = 8,
  parameter int SYNC_TIMEOUT = 1024,
  parameter int CNT_W        = 8
) (
  input logic              CLK,
  input logic              RESET,
  sync_supervisor_if.slave bus
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TCW = $clog2(SYNC_TIMEOUT);

  logic             sd, sd_change;
  logic [1:0]       state_q, state_d;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TCW-1:0]   to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic             link_q;
  code_group_t      pudi_q;

  sd_debounce #(.DEBOUNCE(DEBOUNCE)) u_sd_debounce (
    .CLK      (CLK),
    .RESET    (RESET),
    .raw_i    (bus.SIGNAL_DETECT_RAW),
    .force_i  (bus.MR_LOOPBACK),
    .sd_o     (sd),
    .change_o (sd_change)
  );

  // rst_cnt is only meaningful in HOLD_RST and is zero on every entry to it.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    loss_d    = loss_q;
    if (bus.MR_RESTART) begin
      state_d   = HOLD_RST;
      rst_cnt_d = '0;
    end else if (!sd && (state_q != HOLD_RST)) begin
      // Signal loss outranks a simultaneous CODE_SYNC drop: no loss counted.
      state_d = WAIT_SIGNAL;
    end else begin
      case (state_q)
        HOLD_RST: begin
          if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
            state_d   = WAIT_SIGNAL;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RCW'(1);
          end
        end
        WAIT_SIGNAL: begin
          if (sd) begin
            state_d  = WAIT_SYNC;
            to_cnt_d = '0;
          end
        end
        WAIT_SYNC: begin
          if (bus.CODE_SYNC) begin
            state_d = LINK_OK;
          end else if (to_cnt_q == TCW'(SYNC_TIMEOUT - 1)) begin
            state_d   = HOLD_RST;
            rst_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + TCW'(1);
          end
        end
        LINK_OK: begin
          if (!bus.CODE_SYNC) begin
            state_d  = WAIT_SYNC;
            to_cnt_d = '0;
            loss_d   = (&loss_q) ? loss_q : loss_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = HOLD_RST;
          rst_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= HOLD_RST;
      rst_cnt_q <= '0;
      to_cnt_q  <= '0;
      loss_q    <= '0;
      link_q    <= 1'b0;
      pudi_q    <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      to_cnt_q  <= to_cnt_d;
      loss_q    <= loss_d;
      link_q    <= (state_d == LINK_OK);
      pudi_q    <= bus.MR_LOOPBACK ? bus.TX_CODE : bus.RX_CODE;
    end
  end

  assign bus.SYNC_RESET    = (state_q == HOLD_RST);
  assign bus.SIGNAL_DETECT = sd;
  assign bus.SIGNAL_CHANGE = sd_change;
  assign bus.PUDI          = pudi_q;
  assign bus.LINK_UP       = link_q;
  assign bus.LOSS_COUNT    = loss_q;

endmodule

// File: tb/tb_sync_supervisor.sv
// tb_sync_supervisor: directed scenarios plus randomized stimulus, every
// cycle compared against a behavioural model of the supervisor's rules.
module tb_sync_supervisor;
  import pcs_pkg::*;

  localparam int RST_CYCLES   = 4;
  localparam int DEBOUNCE     = 8;
  localparam int SYNC_TIMEOUT = 16;
  localparam int CNT_W        = 2;
  localparam int LOSS_MAX     = (1 << CNT_W) - 1;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  sync_supervisor_if #(.CNT_W(CNT_W)) bus ();

  sync_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .DEBOUNCE     (DEBOUNCE),
    .SYNC_TIMEOUT (SYNC_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_HOLD, M_WSIG, M_WSYNC, M_UP} mstate_t;
  mstate_t     m_st;
  int          m_hold_left, m_age, m_loss, m_run;
  bit          m_filt, m_sd, m_sd_prev, m_chg;
  logic [9:0]  m_pudi;
  bit          m_pipe[$];   // [0] = synchronized raw, [1] = first stage

  task automatic model_reset();
    m_st        = M_HOLD;
    m_hold_left = RST_CYCLES;
    m_age       = 0;
    m_loss      = 0;
    m_run       = 0;
    m_filt      = 0;
    m_sd        = 0;
    m_sd_prev   = 0;
    m_chg       = 0;
    m_pudi      = '0;
    m_pipe      = '{1'b0, 1'b0};
  endtask

  task automatic model_edge();
    bit sync_v, sd_cur, lb;
    sync_v = m_pipe[0];
    void'(m_pipe.pop_front());
    m_pipe.push_back(bus.SIGNAL_DETECT_RAW);
    sd_cur = m_sd;
    lb     = bus.MR_LOOPBACK;
    // debounce: DEBOUNCE consecutive differing samples move the filter
    if (lb) begin
      m_filt = 0;
      m_run  = 0;
    end else if (sync_v == m_filt) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DEBOUNCE) begin
        m_filt = sync_v;
        m_run  = 0;
      end
    end
    m_chg     = (m_sd != m_sd_prev);
    m_sd_prev = m_sd;
    m_sd      = lb | m_filt;
    // supervisor, decided on the pre-edge filtered signal-detect
    if (bus.MR_RESTART) begin
      m_st        = M_HOLD;
      m_hold_left = RST_CYCLES;
    end else if (!sd_cur && m_st != M_HOLD) begin
      m_st = M_WSIG;
    end else begin
      case (m_st)
        M_HOLD: begin
          m_hold_left--;
          if (m_hold_left == 0) m_st = M_WSIG;
        end
        M_WSIG: begin
          m_st  = M_WSYNC;
          m_age = 0;
        end
        M_WSYNC: begin
          if (bus.CODE_SYNC) m_st = M_UP;
          else begin
            m_age++;
            if (m_age == SYNC_TIMEOUT) begin
              m_st        = M_HOLD;
              m_hold_left = RST_CYCLES;
            end
          end
        end
        M_UP: begin
          if (!bus.CODE_SYNC) begin
            m_st  = M_WSYNC;
            m_age = 0;
            if (m_loss < LOSS_MAX) m_loss++;
          end
        end
      endcase
    end
    m_pudi = lb ? bus.TX_CODE : bus.RX_CODE;
  endtask

  task automatic compare_all();
    check("sync_reset", 32'(bus.SYNC_RESET),    32'(m_st == M_HOLD));
    check("link_up",    32'(bus.LINK_UP),       32'(m_st == M_UP));
    check("signal_det", 32'(bus.SIGNAL_DETECT), 32'(m_sd));
    check("sig_change", 32'(bus.SIGNAL_CHANGE), 32'(m_chg));
    check("pudi",       32'(bus.PUDI),          32'(m_pudi));
    check("loss_count", 32'(bus.LOSS_COUNT),    32'(m_loss));
  endtask

  // Inputs are changed only at the falling edge; outputs compared there too.
  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic wait_link(input int budget);
    int n = 0;
    while (!bus.LINK_UP && n < budget) begin
      tick();
      n++;
    end
    check("link_wait", 32'(bus.LINK_UP), 32'd1);
  endtask

  initial begin
    int sr_hi, sd_rise, chg_n, first_hi, sd_hi;

    bus.SIGNAL_DETECT_RAW = 1'b1;
    bus.MR_LOOPBACK       = 1'b0;
    bus.MR_RESTART        = 1'b0;
    bus.RX_CODE           = 10'h0AA;
    bus.TX_CODE           = 10'h155;
    bus.CODE_SYNC         = 1'b0;
    model_reset();
    #1 RESET = 1'b0;
    #2;
    check("rst_sync_reset", 32'(bus.SYNC_RESET), 32'd1);
    check("rst_loss",       32'(bus.LOSS_COUNT), 32'd0);
    compare_all();

    // Start-up: SYNC_RESET width and signal-detect latency.
    @(negedge CLK);
    RESET = 1'b1;
    sr_hi = 0; sd_rise = -1; chg_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.SYNC_RESET) sr_hi++;
      tick();
      if (bus.SIGNAL_DETECT && sd_rise < 0) sd_rise = i + 1;
      if (bus.SIGNAL_CHANGE) chg_n++;
    end
    check("startup_sr_cycles", 32'(sr_hi), 32'd4);
    check("startup_sd_latency", 32'(sd_rise), 32'd10);
    check("startup_chg_pulses", 32'(chg_n), 32'd1);

    // WAIT_SYNC timeout forces a resync with a fresh SYNC_RESET pulse.
    sr_hi = 0; first_hi = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.SYNC_RESET) begin
        sr_hi++;
        if (first_hi < 0) first_hi = i;
      end
    end
    check("timeout_sr_cycles", 32'(sr_hi), 32'd4);
    check("timeout_entry", 32'(first_hi), 32'd14);

    // CODE_SYNC losses, then saturation of the 2-bit counter.
    bus.CODE_SYNC = 1'b1;
    wait_link(40);
    for (int d = 0; d < 5; d++) begin
      bus.CODE_SYNC = 1'b0;
      tick();
      check("drop_link_low", 32'(bus.LINK_UP), 32'd0);
      bus.CODE_SYNC = 1'b1;
      wait_link(10);
      if (d == 2) check("loss_after_3", 32'(bus.LOSS_COUNT), 32'd3);
    end
    check("loss_saturated", 32'(bus.LOSS_COUNT), 32'd3);

    // Short raw glitch must be filtered out.
    bus.SIGNAL_DETECT_RAW = 1'b0;
    bus.CODE_SYNC         = 1'b0;
    repeat (14) tick();
    sd_hi = 0; chg_n = 0;
    bus.SIGNAL_DETECT_RAW = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) bus.SIGNAL_DETECT_RAW = 1'b0;
      tick();
      if (bus.SIGNAL_DETECT) sd_hi++;
      if (bus.SIGNAL_CHANGE) chg_n++;
    end
    check("glitch_sd", 32'(sd_hi), 32'd0);
    check("glitch_chg", 32'(chg_n), 32'd0);

    // Loopback in and out.
    bus.RX_CODE     = K28_5_RDP;
    bus.TX_CODE     = K28_5_RDN;
    bus.MR_LOOPBACK = 1'b1;
    bus.CODE_SYNC   = 1'b1;
    tick();
    check("lb_pudi", 32'(bus.PUDI), 32'h17C);
    check("lb_comma", 32'(is_comma(bus.PUDI)), 32'd1);
    check("lb_sd", 32'(bus.SIGNAL_DETECT), 32'd1);
    tick();
    check("lb_chg", 32'(bus.SIGNAL_CHANGE), 32'd1);
    tick();
    check("lb_link", 32'(bus.LINK_UP), 32'd1);
    bus.MR_LOOPBACK = 1'b0;
    tick();
    check("unlb_pudi", 32'(bus.PUDI), 32'h283);
    check("unlb_sd", 32'(bus.SIGNAL_DETECT), 32'd0);
    tick();
    check("unlb_link", 32'(bus.LINK_UP), 32'd0);
    check("unlb_chg", 32'(bus.SIGNAL_CHANGE), 32'd1);
    check("unlb_loss", 32'(bus.LOSS_COUNT), 32'd3);

    // Asynchronous reset in WAIT_SYNC clears LOSS_COUNT at once.
    bus.SIGNAL_DETECT_RAW = 1'b1;
    bus.CODE_SYNC         = 1'b0;
    repeat (14) tick();
    #2 RESET = 1'b0;
    #1;
    model_reset();
    check("async_loss", 32'(bus.LOSS_COUNT), 32'd0);
    check("async_sr", 32'(bus.SYNC_RESET), 32'd1);
    compare_all();
    @(negedge CLK);
    RESET = 1'b1;

    // Restart in LINK_OK with a simultaneous CODE_SYNC drop.
    bus.CODE_SYNC = 1'b1;
    wait_link(40);
    bus.CODE_SYNC = 1'b0;
    tick();
    bus.CODE_SYNC = 1'b1;
    wait_link(10);
    bus.MR_RESTART = 1'b1;
    bus.CODE_SYNC  = 1'b0;
    tick();
    check("restart_sr", 32'(bus.SYNC_RESET), 32'd1);
    check("restart_link", 32'(bus.LINK_UP), 32'd0);
    check("restart_loss", 32'(bus.LOSS_COUNT), 32'd1);
    bus.MR_RESTART = 1'b0;
    bus.CODE_SYNC  = 1'b1;
    repeat (3) tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) bus.SIGNAL_DETECT_RAW = ~bus.SIGNAL_DETECT_RAW;
      if ($urandom_range(63) == 0) bus.MR_LOOPBACK = ~bus.MR_LOOPBACK;
      bus.MR_RESTART = ($urandom_range(79) == 0);
      if ($urandom_range(7) == 0) bus.CODE_SYNC = ~bus.CODE_SYNC;
      bus.RX_CODE = 10'($urandom);
      bus.TX_CODE = 10'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
